// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory stage: RV32I load/store width
// encodings, FSM state constants and the alignment-fault rule.
package mem_access_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // Reserved width encodings fault just like an unaligned access.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            LS_B, LS_BU: is_misaligned = 1'b0;
            LS_H, LS_HU: is_misaligned = lane[0];
            LS_W:        is_misaligned = |lane;
            default:     is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Lane select plus sign/zero extension of a RAM word for RV32I loads.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_rdata[{lane, 3'b000} +: 8];
        half_v = mem_rdata[{lane[1], 4'b0000} +: 16];
        case (funct3)
            LS_B:    value = {{24{byte_v[7]}}, byte_v};
            LS_H:    value = {{16{half_v[15]}}, half_v};
            LS_BU:   value = {24'd0, byte_v};
            LS_HU:   value = {16'd0, half_v};
            default: value = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Data-memory stage: answers a start pulse with a single RAM access (load or
// store) and holds the result and completed flag until the next start.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enabled,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  completed,
    output logic [31:0]           rdata,
    output logic                  misaligned,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    state_t      state;
    logic [1:0]  cnt;
    logic        op_load;
    logic [2:0]  op_funct3;
    logic [1:0]  op_lane;
    logic [31:0] ext_value;
    logic        start;
    logic        ld;
    logic        st;
    logic        fault;
    logic        unused_addr_bits;

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   byte_enables = 4'b0001 << lane;
            2'b01:   byte_enables = 4'b0011 << lane;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   replicate = {4{d[7:0]}};
            2'b01:   replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    // A simultaneous load+store request is resolved as a load.
    assign start            = enabled && (state == ST_IDLE || state == ST_DONE);
    assign ld               = is_load;
    assign st               = is_store && !is_load;
    assign fault            = is_misaligned(funct3, addr[1:0]);
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    load_extend u_load_extend (
        .mem_rdata (mem_rdata),
        .lane      (op_lane),
        .funct3    (op_funct3),
        .value     (ext_value)
    );

    // operation latch: only consulted after a start, so it carries no reset
    always_ff @(posedge clk) begin
        if (start) begin
            op_load   <= ld;
            op_funct3 <= funct3;
            op_lane   <= addr[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 2'd0;
            completed  <= 1'b0;
            rdata      <= 32'd0;
            misaligned <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (enabled) begin
                        completed  <= 1'b0;
                        misaligned <= 1'b0;
                        rdata      <= 32'd0;
                        if (!(ld || st)) begin
                            state     <= ST_DONE;
                            completed <= 1'b1;
                        end else if (fault) begin
                            state      <= ST_DONE;
                            completed  <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            state     <= ST_ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= st ? byte_enables(funct3, addr[1:0]) : 4'd0;
                            mem_addr  <= addr[ADDR_WIDTH+1:2];
                            mem_wdata <= replicate(funct3, wdata);
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 4'd0;
                    if (op_load) begin
                        state <= ST_WAIT;
                        cnt   <= 2'(RD_LATENCY - 1);
                    end else begin
                        state     <= ST_DONE;
                        completed <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        rdata     <= ext_value;
                        state     <= ST_DONE;
                        completed <= 1'b1;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: two instances (read latency 1 and 3), each
// attached to its own behavioural byte-enabled RAM.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        enabled;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        completed1, misaligned1, mem_en1;
    logic [31:0] rdata1, mem_wdata1, mem_rdata1;
    logic [3:0]  mem_we1;
    logic [9:0]  mem_addr1;
    logic        completed3, misaligned3, mem_en3;
    logic [31:0] rdata3, mem_wdata3, mem_rdata3;
    logic [3:0]  mem_we3;
    logic [9:0]  mem_addr3;

    logic [31:0] ram1 [0:1023];
    logic [31:0] ram3 [0:1023];
    logic [31:0] rp1;
    logic [31:0] rp3 [0:2];

    int tests = 0;
    int fails = 0;

    int          c1, c3, en1_cyc, en1_cnt, en3_cnt, overlap;
    logic        low1;
    logic [9:0]  ma1;
    logic [3:0]  mw1;
    logic [31:0] md1;

    always #5 clk = ~clk;

    mem_access #(.ADDR_WIDTH(10), .RD_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .enabled(enabled), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .completed(completed1), .rdata(rdata1),
        .misaligned(misaligned1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    mem_access #(.ADDR_WIDTH(10), .RD_LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .enabled(enabled), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .completed(completed3), .rdata(rdata3),
        .misaligned(misaligned3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    always @(posedge clk) begin
        if (mem_en1) begin
            for (int i = 0; i < 4; i++)
                if (mem_we1[i]) ram1[mem_addr1][8*i +: 8] <= mem_wdata1[8*i +: 8];
            rp1 <= ram1[mem_addr1];
        end
        if (mem_en3) begin
            for (int i = 0; i < 4; i++)
                if (mem_we3[i]) ram3[mem_addr3][8*i +: 8] <= mem_wdata3[8*i +: 8];
            rp3[0] <= ram3[mem_addr3];
        end
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign mem_rdata1 = rp1;
    assign mem_rdata3 = rp3[2];

    // Cycle 0 is the cycle whose closing edge samples enabled; c1/c3 hold the
    // first cycle each instance shows completed=1 (0 if it never does).
    task automatic run_op(input logic now, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        if (!now) @(negedge clk);
        is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd; enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        c1 = 0; c3 = 0; en1_cyc = 0; en1_cnt = 0; en3_cnt = 0; low1 = !completed1;
        ma1 = '0; mw1 = '0; md1 = '0;
        for (int k = 1; k <= 20; k++) begin
            if (mem_en1) begin
                en1_cnt++; en1_cyc = k; ma1 = mem_addr1; mw1 = mem_we1; md1 = mem_wdata1;
            end
            if (mem_en3) en3_cnt++;
            if ((mem_en1 && completed1) || (mem_en3 && completed3)) overlap++;
            if (completed1 && c1 == 0) c1 = k;
            if (completed3 && c3 == 0) c3 = k;
            if (c1 != 0 && c3 != 0) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        tests++; if (completed1 !== 1'b0) begin fails++; $display("FAIL reset_completed: got %b want 0", completed1); end
        tests++; if (rdata1 !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata1); end
        tests++; if (misaligned1 !== 1'b0) begin fails++; $display("FAIL reset_misaligned: got %b want 0", misaligned1); end
        tests++; if ({mem_en1, mem_we1} !== 5'd0) begin fails++; $display("FAIL reset_strobes: got %b want 0", {mem_en1, mem_we1}); end
        tests++; if ({mem_addr1, mem_wdata1} !== 42'd0) begin fails++; $display("FAIL reset_addr_data: got %h want 0", {mem_addr1, mem_wdata1}); end
        tests++; if ({completed3, mem_en3} !== 2'd0) begin fails++; $display("FAIL reset_lat3: got %b want 0", {completed3, mem_en3}); end
    endtask

    task automatic test_store_word;
        run_op(1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        tests++; if (en1_cyc !== 1 || en1_cnt !== 1) begin fails++; $display("FAIL sw_access_cycle: got cyc %0d cnt %0d want 1/1", en1_cyc, en1_cnt); end
        tests++; if (ma1 !== 10'd4) begin fails++; $display("FAIL sw_mem_addr: got %h want 4", ma1); end
        tests++; if (mw1 !== 4'b1111) begin fails++; $display("FAIL sw_mem_we: got %b want 1111", mw1); end
        tests++; if (md1 !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_mem_wdata: got %h want deadbeef", md1); end
        tests++; if (c1 !== 2 || c3 !== 2) begin fails++; $display("FAIL sw_latency: got %0d/%0d want 2/2", c1, c3); end
        tests++; if (rdata1 !== 32'd0 || misaligned1 !== 1'b0) begin fails++; $display("FAIL sw_result: got %h/%b want 0/0", rdata1, misaligned1); end
    endtask

    task automatic test_byte;
        run_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h13, 32'h000000A5);
        tests++; if (mw1 !== 4'b1000) begin fails++; $display("FAIL sb_mem_we: got %b want 1000", mw1); end
        tests++; if (md1 !== 32'hA5A5A5A5) begin fails++; $display("FAIL sb_mem_wdata: got %h want a5a5a5a5", md1); end
        run_op(1'b0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        tests++; if (rdata1 !== 32'hFFFFFFA5) begin fails++; $display("FAIL lb_rdata: got %h want ffffffa5", rdata1); end
        tests++; if (c1 !== 3) begin fails++; $display("FAIL lb_latency1: got %0d want 3", c1); end
        tests++; if (c3 !== 5 || rdata3 !== 32'hFFFFFFA5) begin fails++; $display("FAIL lb_lat3: got %0d/%h want 5/ffffffa5", c3, rdata3); end
        tests++; if (mw1 !== 4'b0000) begin fails++; $display("FAIL lb_no_write: got %b want 0000", mw1); end
        run_op(1'b0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        tests++; if (rdata1 !== 32'h000000A5) begin fails++; $display("FAIL lbu_rdata: got %h want 000000a5", rdata1); end
        run_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        tests++; if (rdata1 !== 32'hA5ADBEEF) begin fails++; $display("FAIL sb_merge: got %h want a5adbeef", rdata1); end
    endtask

    task automatic test_half;
        run_op(1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h80017FFF);
        run_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
        tests++; if (rdata1 !== 32'hFFFF8001) begin fails++; $display("FAIL lh_hi: got %h want ffff8001", rdata1); end
        run_op(1'b0, 1'b1, 1'b0, 3'b101, 32'h22, 32'h0);
        tests++; if (rdata1 !== 32'h00008001) begin fails++; $display("FAIL lhu_hi: got %h want 00008001", rdata1); end
        run_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h20, 32'h0);
        tests++; if (rdata1 !== 32'h00007FFF) begin fails++; $display("FAIL lh_lo: got %h want 00007fff", rdata1); end
        // address bits above the RAM size wrap
        run_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h1020, 32'h0);
        tests++; if (rdata1 !== 32'h80017FFF || ma1 !== 10'd8) begin fails++; $display("FAIL lw_wrap: got %h@%h want 80017fff@8", rdata1, ma1); end
    endtask

    task automatic test_misaligned;
        run_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        tests++; if (misaligned1 !== 1'b1 || c1 !== 1) begin fails++; $display("FAIL lw_fault: got %b at %0d want 1 at 1", misaligned1, c1); end
        tests++; if (en1_cnt !== 0 || en3_cnt !== 0) begin fails++; $display("FAIL lw_fault_no_ram: got %0d/%0d want 0/0", en1_cnt, en3_cnt); end
        tests++; if (rdata1 !== 32'd0) begin fails++; $display("FAIL lw_fault_rdata: got %h want 0", rdata1); end
        run_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h01, 32'h0);
        tests++; if (misaligned1 !== 1'b1 || c1 !== 1 || en1_cnt !== 0) begin fails++; $display("FAIL lh_fault: got %b at %0d en %0d want 1 at 1 en 0", misaligned1, c1, en1_cnt); end
        run_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h01, 32'h0000005A);
        tests++; if (misaligned1 !== 1'b0 || c1 !== 2) begin fails++; $display("FAIL sb_odd: got %b at %0d want 0 at 2", misaligned1, c1); end
        tests++; if (mw1 !== 4'b0010) begin fails++; $display("FAIL sb_odd_we: got %b want 0010", mw1); end
        run_op(1'b0, 1'b1, 1'b0, 3'b011, 32'h00, 32'h0);
        tests++; if (misaligned1 !== 1'b1 || en1_cnt !== 0) begin fails++; $display("FAIL f3_reserved: got %b en %0d want 1 en 0", misaligned1, en1_cnt); end
        run_op(1'b0, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        tests++; if (c1 !== 1 || misaligned1 !== 1'b0 || en1_cnt !== 0) begin fails++; $display("FAIL noop: got %0d/%b/%0d want 1/0/0", c1, misaligned1, en1_cnt); end
    endtask

    task automatic test_latency3;
        int cyc3;
        int extra;
        @(negedge clk);
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h10; enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        @(negedge clk);
        // both instances are in WAIT here; this start must be dropped
        is_load = 1'b0; is_store = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; enabled = 1'b1;
        cyc3 = 0; extra = 0;
        for (int k = 2; k <= 20; k++) begin
            if (k == 3) enabled = 1'b0;
            if (mem_en1 || mem_en3) extra++;
            if (completed3 && cyc3 == 0) cyc3 = k;
            if (cyc3 != 0) break;
            @(negedge clk);
        end
        tests++; if (cyc3 !== 5) begin fails++; $display("FAIL lw_lat3_cycle: got %0d want 5", cyc3); end
        tests++; if (rdata3 !== 32'hA5ADBEEF) begin fails++; $display("FAIL lw_lat3_rdata: got %h want a5adbeef", rdata3); end
        tests++; if (extra !== 0) begin fails++; $display("FAIL wait_ignores_enabled: got %0d strobes want 0", extra); end

        run_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        @(negedge clk);
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h20; enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if ({completed3, misaligned3, mem_en3, mem_we3} !== 7'd0) begin fails++; $display("FAIL rst_wait_ctrl: got %b want 0", {completed3, misaligned3, mem_en3, mem_we3}); end
        tests++; if ({rdata3, mem_addr3, mem_wdata3} !== 74'd0) begin fails++; $display("FAIL rst_wait_data: got %h want 0", {rdata3, mem_addr3, mem_wdata3}); end
        @(negedge clk);
        @(negedge clk);
        tests++; if ({completed3, mem_en3} !== 2'd0) begin fails++; $display("FAIL rst_no_strobe: got %b want 0", {completed3, mem_en3}); end
        rst = 1'b0;
        run_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        tests++; if (c3 !== 5 || rdata3 !== 32'h80017FFF) begin fails++; $display("FAIL lw_after_rst: got %0d/%h want 5/80017fff", c3, rdata3); end
    endtask

    task automatic test_back_to_back;
        run_op(1'b0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678);
        run_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        tests++; if (low1 !== 1'b1) begin fails++; $display("FAIL b2b_completed_drop: got completed=%b want 0", !low1); end
        tests++; if (c1 !== 3 || rdata1 !== 32'h12345678) begin fails++; $display("FAIL b2b_lw_lat1: got %0d/%h want 3/12345678", c1, rdata1); end
        tests++; if (c3 !== 5 || rdata3 !== 32'h12345678) begin fails++; $display("FAIL b2b_lw_lat3: got %0d/%h want 5/12345678", c3, rdata3); end
        tests++; if (overlap !== 0) begin fails++; $display("FAIL strobe_with_completed: got %0d cycles want 0", overlap); end
    endtask

    initial begin
        rst = 1'b1; enabled = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'b000; addr = 32'd0; wdata = 32'd0; overlap = 0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_store_word;
        test_byte;
        test_half;
        test_misaligned;
        test_latency3;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
